// File: rtl/adder_seq64.sv
// -----------------------------------------------------------------------------
// adder_seq64 -- sequential wide adder built from one time-shared 16-bit
// carry-lookahead adder.
//
// Operands of W = 16*N_SLICE bits are accepted with a valid/ready handshake.
// One 16-bit slice is added per clock, least significant first, with the
// carry chained through a register between slices. The result is held until
// the consumer takes it.
//
// Optional feature: define ADDER_SEQ_SUB_EN to add the `sub` input. When it
// is 1 at accept, y is inverted and the initial carry is forced to 1, so the
// block computes x - y (c_out = 1 means no borrow).
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand set offered
//   in_ready   block can accept operands (IDLE only)
//   x, y       operands, W bits
//   c_in       carry into slice 0
//   sub        (ADDER_SEQ_SUB_EN only) subtract select, sampled at accept
//   out_valid  result held and valid (DONE only)
//   out_ready  consumer takes result
//   sum        registered result, modulo 2^W
//   c_out      carry out of the top slice
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
//   busy       high while an operation is in progress or awaiting hand-off
// -----------------------------------------------------------------------------

// 16-bit carry-lookahead adder: 4-bit groups with generate/propagate, and the
// group carries formed directly from c_in rather than rippled.
module AdderAhead16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] s,
  output logic        c_out,
  output logic        c_msb   // carry into bit 15, used for overflow
);

  logic [15:0] g, p;
  logic [3:0]  gg, pg;
  logic [16:0] c;

  // NOTE: every variable gets a default at the top of an always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    c  = '0;

    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end

    c[0]  = c_in;
    c[4]  = gg[0] | (pg[0] & c_in);
    c[8]  = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c_in);
    c[12] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & c_in);
    c[16] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & c_in);

    // Carries inside a group hang off the group carry-in; the recurrence is
    // only three deep and flattens to two-level logic.
    for (int k = 0; k < 4; k++) begin
      for (int j = 1; j < 4; j++) begin
        c[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & c[4*k+j-1]);
      end
    end
  end

  assign s     = p ^ c[15:0];
  assign c_out = c[16];
  assign c_msb = c[15];

endmodule

module adder_seq64 #(
  parameter int N_SLICE = 4,
  parameter int W       = 16 * N_SLICE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
`ifdef ADDER_SEQ_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         ovf,
  output logic         busy
);

  if (N_SLICE < 2 || N_SLICE > 8) begin : g_bad_param
    $error("adder_seq64: N_SLICE must be in 2..8");
  end

  localparam int                IDX_W    = $clog2(N_SLICE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_SLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]   x_q, y_q;
  logic           carry_q;

  logic [15:0]    slice_a, slice_b, slice_s;
  logic           slice_c_out, slice_c_msb;

  assign slice_a = x_q[16*idx +: 16];
  assign slice_b = y_q[16*idx +: 16];

  // The only adder in the block; every slice passes through it in turn.
  AdderAhead16 u_adder (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c_out),
    .c_msb (slice_c_msb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q       <= x;
            idx       <= '0;
`ifdef ADDER_SEQ_SUB_EN
            // Two's-complement subtract: x + ~y + 1.
            y_q       <= sub ? ~y : y;
            carry_q   <= sub ? 1'b1 : c_in;
`else
            y_q       <= y;
            carry_q   <= c_in;
`endif
            state     <= RUN;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end

        RUN: begin
          sum[16*idx +: 16] <= slice_s;
          carry_q           <= slice_c_out;
          idx               <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            c_out     <= slice_c_out;
            ovf       <= slice_c_msb ^ slice_c_out;
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq64.sv
// -----------------------------------------------------------------------------
// tb_adder_seq64 -- self-checking bench for adder_seq64 (N_SLICE = 4, W = 64).
// Directed vectors with hand-computed results, plus sequences for reset,
// output stall and handshake corner cases. Subtract vectors are compiled only
// when ADDER_SEQ_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_adder_seq64;

  localparam int N_SLICE = 4;
  localparam int W       = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;
`ifdef ADDER_SEQ_SUB_EN
  logic         sub;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder_seq64 #(.N_SLICE(N_SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .c_in      (c_in),
`ifdef ADDER_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c_in;
    logic         sub;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one operand set from IDLE, check latency and result, then complete
  // the output handshake with in_valid held high to show no back-to-back
  // accept happens in the handshake cycle.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    check({name, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    x        = v.x;
    y        = v.y;
    c_in     = v.c_in;
`ifdef ADDER_SEQ_SUB_EN
    sub      = v.sub;
`endif
    @(posedge clk); #1;             // accept edge
    in_valid = 1'b0;
    x        = ~v.x;                 // garbage after accept must be ignored
    y        = 64'hDEAD_BEEF_0BAD_F00D;
    c_in     = ~v.c_in;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(N_SLICE));
    check({name, " sum"},   sum,        v.sum);
    check({name, " c_out"}, 64'(c_out), 64'(v.c_out));
    check({name, " ovf"},   64'(ovf),   64'(v.ovf));
    check({name, " busy in DONE"}, 64'(busy), 64'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;             // handshake edge
    out_ready = 1'b0;
    check({name, " out_valid after hs"}, 64'(out_valid), 64'd0);
    check({name, " in_ready after hs"},  64'(in_ready),  64'd1);
    check({name, " busy after hs"},      64'(busy),      64'd0);
    in_valid = 1'b0;
  endtask

  vec_t vecs[9];
  vec_t v;
  logic [W-1:0] held;

  initial begin
    vecs[0] = '{64'h1, 64'h0, 1'b0, 1'b0, 64'h1, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'h0000_FFFF_0000_FFFF, 64'h0, 1'b1, 1'b0,
                64'h0000_FFFF_0001_0000, 1'b0, 1'b0};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
                64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
    vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
    vecs[8] = '{64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0, 1'b0,
                64'h0000_0001_0000_0000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; c_in = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    check("reset in_ready",  64'(in_ready),  64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum",       sum,            64'd0);
    check("reset c_out",     64'(c_out),     64'd0);
    check("reset ovf",       64'(ovf),       64'd0);
    check("reset busy",      64'(busy),      64'd0);

    // out_ready while idle does nothing.
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle out_ready in_ready",  64'(in_ready),  64'd1);
    check("idle out_ready out_valid", 64'(out_valid), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

`ifdef ADDER_SEQ_SUB_EN
    v = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    run_vec(v, "sub 5-7");
    @(posedge clk); #1;
    v = '{64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0};   // c_in ignored
    run_vec(v, "sub 7-5");
    @(posedge clk); #1;
`endif

    // Output stall: hold out_ready low 10 cycles with a new operand offered.
    v = vecs[5];
    in_valid = 1'b1; x = v.x; y = v.y; c_in = v.c_in;
`ifdef ADDER_SEQ_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk); #1;
    x = 64'h1; y = 64'h1; c_in = 1'b0;          // in_valid stays high
    repeat (N_SLICE) @(posedge clk); #1;
    check("stall out_valid", 64'(out_valid), 64'd1);
    held = sum;
    check("stall first sum", held, v.sum);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall sum c%0d", i), sum, v.sum);
      check($sformatf("stall in_ready c%0d", i), 64'(in_ready), 64'd0);
    end
    check("stall out_valid end", 64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall release in_ready", 64'(in_ready), 64'd1);

    // Reset mid-RUN discards the operation.
    in_valid = 1'b1; x = 64'hFFFF_FFFF_FFFF_FFFF; y = 64'h1; c_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("midrun rst out_valid", 64'(out_valid), 64'd0);
    check("midrun rst in_ready",  64'(in_ready),  64'd1);
    check("midrun rst sum",       sum,            64'd0);

    // Reset in DONE clears the held result.
    in_valid = 1'b1; x = 64'h1234; y = 64'h1; c_in = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (N_SLICE) @(posedge clk); #1;
    check("pre-rst done out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("done rst out_valid", 64'(out_valid), 64'd0);
    check("done rst sum",       sum,            64'd0);
    check("done rst in_ready",  64'(in_ready),  64'd1);

    // Normal operation resumes after reset.
    run_vec(vecs[2], "post-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_seq64.md
ADDER_SEQ64 -- requirements
Module: adder_seq64

Interface
REQ-001 Parameter N_SLICE, default 4, number of 16-bit slices; operand width W = 16*N_SLICE; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 x  input  W  operand A.
REQ-007 y  input  W  operand B.
REQ-008 c_in  input  1  carry into slice 0.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  W  registered result.
REQ-012 c_out  output  1  carry out of the top slice.
REQ-013 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 A single 16-bit carry-lookahead adder instance (AdderAhead16) SHALL be time-shared across slices; no second adder instance is permitted.
REQ-016 FSM states IDLE, RUN, DONE; IDLE→RUN on in_valid&in_ready; RUN→DONE after slice N_SLICE-1; DONE→IDLE on out_valid&out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 On accept, x, y and c_in SHALL be latched; the slice index resets to 0 and the carry register loads c_in.
REQ-019 Each RUN cycle SHALL add latched slice idx of x and y with the carry register, write sum[16*idx+15:16*idx], load the carry register with the adder c_out, and increment idx.
REQ-020 Latency: out_valid SHALL rise exactly N_SLICE cycles after the accept edge (4 for the default).
REQ-021 sum, c_out, ovf SHALL be stable in DONE until the handshake completes; out_ready low stalls indefinitely.
REQ-022 in_ready SHALL rise the cycle after the output handshake; no back-to-back accept in the handshake cycle.
REQ-023 Inputs x, y, c_in SHALL be ignored outside the accept cycle; in_valid in RUN/DONE has no effect.
REQ-024 Carry out of the top slice SHALL wrap: sum is modulo 2^W; c_out reports the wrapped carry.
REQ-025 out_ready asserted while out_valid is low SHALL have no effect.

Reset
REQ-026 rst SHALL asynchronously force IDLE, idx=0, carry register=0, sum=0, c_out=0, ovf=0, out_valid=0, busy=0; in_ready=1 after release.
REQ-027 Reset mid-RUN or in DONE SHALL discard the operation with no partial result visible afterwards.

Configuration
REQ-028 Macro ADDER_SEQ_SUB_EN: when defined, an input port sub (1 bit) SHALL exist, sampled at accept; sub=1 latches ~y and forces the carry register to 1 (c_in ignored), giving x-y; c_out=1 means no borrow.
REQ-029 Without ADDER_SEQ_SUB_EN the sub port SHALL be absent and the block only adds.

Verification
REQ-030 rst pulse mid-RUN → out_valid=0, in_ready=1, sum=0 next cycle after release.
REQ-031 x=1, y=0, c_in=0 → after 4 cycles out_valid=1, sum=1, c_out=0, ovf=0.
REQ-032 x=64'hFFFF_FFFF_FFFF_FFFF, y=1, c_in=0 → sum=0, c_out=1, ovf=0 (carry ripples through all slices).
REQ-033 x=64'h7FFF_FFFF_FFFF_FFFF, y=1 → sum=64'h8000_0000_0000_0000, c_out=0, ovf=1.
REQ-034 out_ready held low 10 cycles in DONE → sum unchanged, in_ready=0; new in_valid ignored until handshake.
REQ-035 With ADDER_SEQ_SUB_EN: x=5, y=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, c_out=0.
